// File: rtl/led_sequencer.sv
// LED index sequencer: steps a 4-bit decoder index through one of four patterns.
// Optional LED_SEQ_PAUSE_EN adds an i_Pause input that freezes a running sequence.
module led_sequencer #(
  parameter int CLKS_PER_STEP = 25_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Stop,
`ifdef LED_SEQ_PAUSE_EN
  input  logic       i_Pause,
`endif
  input  logic [1:0] i_Mode,
  output logic [3:0] o_LED_Value,
  output logic       o_Busy,
  output logic       o_Step,
  output logic       o_Done
);

  localparam int CNT_W = (CLKS_PER_STEP > 2) ? $clog2(CLKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_STEP - 1);

  localparam logic [1:0] M_UP     = 2'b00;
  localparam logic [1:0] M_DOWN   = 2'b01;
  localparam logic [1:0] M_BOUNCE = 2'b10;
  localparam logic [1:0] M_SWEEP  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       val, val_n, adv_val;
  logic             dir_up, dir_n, adv_dir;
  logic [1:0]       mode, mode_n;
  logic             busy, busy_n;
  logic             step, step_n;
  logic             done, done_n;
  logic             pause;
  logic             last;

`ifdef LED_SEQ_PAUSE_EN
  assign pause = i_Pause;
`else
  assign pause = 1'b0;
`endif

  assign last = (cnt == CNT_MAX);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      val    <= 4'h0;
      dir_up <= 1'b1;
      mode   <= M_UP;
      busy   <= 1'b0;
      step   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      val    <= val_n;
      dir_up <= dir_n;
      mode   <= mode_n;
      busy   <= busy_n;
      step   <= step_n;
      done   <= done_n;
    end
  end

  // Next position for the latched pattern; bounce turns at the endpoints
  always_comb begin
    adv_val = val + 4'd1;
    adv_dir = dir_up;
    unique case (mode)
      M_DOWN: adv_val = val - 4'd1;
      M_BOUNCE: begin
        if (dir_up) begin
          if (val == 4'hF) begin
            adv_val = 4'hE;
            adv_dir = 1'b0;
          end
        end else if (val == 4'h0) begin
          adv_val = 4'h1;
          adv_dir = 1'b1;
        end else begin
          adv_val = val - 4'd1;
        end
      end
      default: adv_val = val + 4'd1;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    val_n   = val;
    dir_n   = dir_up;
    mode_n  = mode;
    busy_n  = busy;
    step_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_Start && !i_Stop) begin
          state_n = RUN;
          busy_n  = 1'b1;
          cnt_n   = '0;
          mode_n  = i_Mode;
          dir_n   = 1'b1;
          val_n   = (i_Mode == M_DOWN) ? 4'hF : 4'h0;
        end
      end
      RUN: begin
        if (i_Stop) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end else if (!pause) begin
          if (!last) begin
            cnt_n = cnt + 1'b1;
          end else begin
            cnt_n = '0;
            if (mode == M_SWEEP && val == 4'hF) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              val_n  = adv_val;
              dir_n  = adv_dir;
              step_n = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_LED_Value = val;
  assign o_Busy      = busy;
  assign o_Step      = step;
  assign o_Done      = done;

endmodule

// File: tb/tb_led_sequencer.sv
// Testbench for led_sequencer: directed scenarios plus randomized runs
// checked against a step-count model of the LED patterns.
module tb_led_sequencer;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] led;
  logic       busy, step, done;
`ifdef LED_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  led_sequencer #(.CLKS_PER_STEP(CPS)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Start     (start),
    .i_Stop      (stop),
`ifdef LED_SEQ_PAUSE_EN
    .i_Pause     (pause),
`endif
    .i_Mode      (mode),
    .o_LED_Value (led),
    .o_Busy      (busy),
    .o_Step      (step),
    .o_Done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Position after k steps, derived from the pattern definitions
  function automatic logic [3:0] fval(input logic [1:0] m, input int k);
    int p;
    case (m)
      2'b00: p = k % 16;
      2'b01: p = 15 - (k % 16);
      2'b10: begin
        p = k % 30;
        if (p > 15) p = 30 - p;
      end
      default: p = (k > 15) ? 15 : k;
    endcase
    return 4'(p);
  endfunction

  function automatic logic fstep(input int e);
    return (e > 0) && (e % CPS == 0);
  endfunction

  task automatic begin_run(input logic [1:0] m);
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_run;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({led, busy, step, done} !== 7'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got led=%0d busy=%b step=%b done=%b want 0",
                 i, led, busy, step, done);
      end
      tick();
    end
  endtask

  task automatic test_up_wrap;
    int nsteps = 0;
    begin_run(2'b00);
    for (int e = 0; e <= 16 * CPS; e++) begin
      total++;
      if (busy !== 1'b1 || led !== fval(2'b00, e / CPS) || step !== fstep(e)) begin
        bad++;
        $display("FAIL up_wrap e=%0d got led=%0d busy=%b step=%b want led=%0d busy=1 step=%b",
                 e, led, busy, step, fval(2'b00, e / CPS), fstep(e));
      end
      if (step === 1'b1) nsteps++;
      if (e < 16 * CPS) tick();
    end
    total++;
    if (nsteps != 16) begin
      bad++;
      $display("FAIL up_wrap_steps got %0d want 16", nsteps);
    end
    end_run();
  endtask

  task automatic test_bounce;
    begin_run(2'b10);
    for (int e = 0; e <= 31 * CPS; e++) begin
      total++;
      if (busy !== 1'b1 || led !== fval(2'b10, e / CPS) || step !== fstep(e)) begin
        bad++;
        $display("FAIL bounce e=%0d got led=%0d step=%b want led=%0d step=%b",
                 e, led, step, fval(2'b10, e / CPS), fstep(e));
      end
      tick();
    end
    end_run();
  endtask

  task automatic test_single_sweep;
    int nsteps = 0;
    begin_run(2'b11);
    for (int e = 0; e < 16 * CPS; e++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0 || led !== fval(2'b11, e / CPS)
          || step !== fstep(e)) begin
        bad++;
        $display("FAIL sweep e=%0d got led=%0d busy=%b step=%b done=%b want led=%0d",
                 e, led, busy, step, done, fval(2'b11, e / CPS));
      end
      if (step === 1'b1) nsteps++;
      tick();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || step !== 1'b0 || led !== 4'hF) begin
      bad++;
      $display("FAIL sweep_done got done=%b busy=%b step=%b led=%0d want 1 0 0 15",
               done, busy, step, led);
    end
    total++;
    if (nsteps != 15) begin
      bad++;
      $display("FAIL sweep_steps got %0d want 15", nsteps);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || led !== 4'hF) begin
      bad++;
      $display("FAIL sweep_after got done=%b busy=%b led=%0d want 0 0 15", done, busy, led);
    end
  endtask

  task automatic test_stop_priority;
    begin_run(2'b01);
    for (int e = 0; e < 4 * CPS - 1; e++) tick();
    total++;
    if (led !== 4'd12 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stop_setup got led=%0d busy=%b want 12 1", led, busy);
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || led !== 4'd12 || step !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL stop_prio got busy=%b led=%0d step=%b done=%b want 0 12 0 0",
               busy, led, step, done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (busy !== 1'b0 || led !== 4'd12 || step !== 1'b0) begin
        bad++;
        $display("FAIL stop_idle cyc=%0d got busy=%b led=%0d want 0 12", i, busy, led);
      end
    end
    start = 1'b0;
    stop = 1'b0;
    tick();
  endtask

  task automatic test_mode_latch_reset;
    begin_run(2'b00);
    for (int e = 0; e <= 6 * CPS; e++) begin
      if (e == 3 * CPS) mode = 2'b01;
      total++;
      if (busy !== 1'b1 || led !== fval(2'b00, e / CPS) || step !== fstep(e)) begin
        bad++;
        $display("FAIL mode_latch e=%0d got led=%0d want %0d", e, led, fval(2'b00, e / CPS));
      end
      if (e < 6 * CPS) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({led, busy, step, done} !== 7'b0) begin
      bad++;
      $display("FAIL midrun_reset got led=%0d busy=%b step=%b done=%b want 0",
               led, busy, step, done);
    end
    tick();
    total++;
    if (busy !== 1'b0 || led !== 4'd0) begin
      bad++;
      $display("FAIL reset_stays_idle got busy=%b led=%0d want 0 0", busy, led);
    end
  endtask

`ifdef LED_SEQ_PAUSE_EN
  task automatic test_pause;
    int e = 0;
    begin_run(2'b00);
    for (int c = 0; c < 4 * CPS + 10; c++) begin
      pause = (c >= 2 * CPS + 1) && (c < 2 * CPS + 11);
      total++;
      if (busy !== 1'b1 || led !== fval(2'b00, e / CPS) || step !== fstep(e)) begin
        bad++;
        $display("FAIL pause c=%0d got led=%0d step=%b want led=%0d step=%b",
                 c, led, step, fval(2'b00, e / CPS), fstep(e));
      end
      tick();
      if (!pause) e++;
      else if (step !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL pause_step c=%0d got 1 want 0", c);
      end
    end
    pause = 1'b0;
    end_run();
  endtask
`endif

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      logic [1:0] m;
      int len, e;
      logic run;
      m = 2'($urandom_range(0, 3));
      len = $urandom_range(3, 90);
      begin_run(m);
      e = 0;
      run = 1'b1;
      for (int c = 0; run && c <= len; c++) begin
        logic [3:0] cur;
        cur = fval(m, e / CPS);
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || led !== cur || step !== fstep(e)) begin
          bad++;
          $display("FAIL rand it=%0d m=%0d e=%0d got led=%0d busy=%b step=%b want led=%0d step=%b",
                   it, m, e, led, busy, step, cur, fstep(e));
        end
        mode = 2'($urandom_range(0, 3));
        start = 1'($urandom_range(0, 1));
        stop = (c == len);
        tick();
        if (stop) begin
          run = 1'b0;
          total++;
          if (busy !== 1'b0 || led !== cur || step !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rand_stop it=%0d got busy=%b led=%0d step=%b want 0 %0d 0",
                     it, busy, led, step, cur);
          end
        end else begin
          e++;
          if (m == 2'b11 && e == 16 * CPS) begin
            run = 1'b0;
            total++;
            if (done !== 1'b1 || busy !== 1'b0 || led !== 4'hF || step !== 1'b0) begin
              bad++;
              $display("FAIL rand_done it=%0d got done=%b busy=%b led=%0d", it, done, busy, led);
            end
          end
        end
      end
      start = 1'b0;
      stop = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL rand_idle it=%0d got busy=%b want 0", it, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_bounce();
    test_single_sweep();
    test_stop_priority();
    test_mode_latch_reset();
`ifdef LED_SEQ_PAUSE_EN
    test_pause();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
